// File: rtl/reg_file_bank.sv
// Register file written through a one-hot wordline, with two combinational read
// ports, write-to-read bypass, optional hard-wired zero register and a sticky multi-hot flag.
module reg_file_bank #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ZERO_REG = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REGS-1:0]         wordline,
  input  logic [DATA_W-1:0]           write_data,
  input  logic [$clog2(NUM_REGS)-1:0] src_reg1,
  input  logic [$clog2(NUM_REGS)-1:0] src_reg2,
  output logic [DATA_W-1:0]           src_data1,
  output logic [DATA_W-1:0]           src_data2,
  output logic                        wl_error
);

  localparam int ID_W = $clog2(NUM_REGS);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] we;
  logic                wl_any;
  logic                wl_multi;
  logic                wl_onehot;
  logic                err_q;
  logic                err_d;

  // Popcount classification: wl_multi rises on the second set bit seen.
  always_comb begin
    wl_any   = 1'b0;
    wl_multi = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wordline[i]) begin
        if (wl_any) wl_multi = 1'b1;
        wl_any = 1'b1;
      end
    end
  end

  assign wl_onehot = wl_any & ~wl_multi;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_we
      assign we[gi] = wl_onehot & wordline[gi] & ((ZERO_REG == 0) || (gi != 0));
    end
  endgenerate

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (we[i]) regs_d[i] = write_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign err_d = err_q | wl_multi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign wl_error = err_q;

  // Bypass is masked while rst is high so reads show 0 for the whole reset.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [ID_W-1:0]   id;
      logic              byp;
      logic [DATA_W-1:0] data;

      assign id  = (gi == 0) ? src_reg1 : src_reg2;
      assign byp = wl_onehot & wordline[id] & ~rst;

      always_comb begin
        data = regs_q[id];
        if (byp) data = write_data;
        if ((ZERO_REG != 0) && (id == '0)) data = '0;
      end
    end
  endgenerate

  assign src_data1 = g_rd[0].data;
  assign src_data2 = g_rd[1].data;

endmodule
